// File: rtl/cirno9_boot_pkg.sv
// Shared definitions for the cirno9 boot loader: FSM encoding and the default
// frame start marker.
package cirno9_boot_pkg;

   typedef enum logic [2:0] {
      ST_SYNC,
      ST_HDR,
      ST_DATA,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } boot_state_e;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/cirno9_byte_packer.sv
// Little-endian byte-to-word packer with a one-cycle SRAM write strobe issued
// the cycle after the fourth byte of each word is pushed.
module cirno9_byte_packer #(
   parameter int ADDR_W = 14
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clr_i,
   input  logic              push_i,
   input  logic [7:0]        byte_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic              word_last_o,
   output logic              we_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [31:0]       wdata_o
);

   logic [1:0]        lane_q, lane_d;
   logic [23:0]       word_q, word_d;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;

   assign word_last_o = push_i && (lane_q == 2'd3);

   always_comb begin
      lane_d = lane_q;
      word_d = word_q;
      if (clr_i) begin
         lane_d = '0;
      end else if (push_i) begin
         lane_d = lane_q + 2'd1;
         case (lane_q)
            2'd0:    word_d[7:0]   = byte_i;
            2'd1:    word_d[15:8]  = byte_i;
            2'd2:    word_d[23:16] = byte_i;
            default: ;
         endcase
      end
   end

   // The top byte is taken straight from the input so the word retires in the same cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lane_q  <= '0;
         word_q  <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         lane_q <= lane_d;
         word_q <= word_d;
         we_q   <= word_last_o;
         if (word_last_o) begin
            addr_q  <= addr_i;
            wdata_q <= {byte_i, word_q};
         end
      end
   end

   assign we_o    = we_q;
   assign addr_o  = addr_q;
   assign wdata_o = wdata_q;

endmodule

// File: rtl/cirno9_boot_loader.sv
// Framed byte-stream program loader: writes the image into SRAM and releases
// the core from reset once the frame checksum verifies.
module cirno9_boot_loader #(
   parameter int          ADDR_W    = 14,
   parameter int          BASE_WORD = 0,
   parameter int          MAX_WORDS = 16384,
   parameter logic [7:0]  SYNC_BYTE = cirno9_boot_pkg::SYNC_BYTE_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              byte_vld,
   input  logic [7:0]        byte_dat,
   output logic              byte_rdy,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_wdata,
   output logic              core_rst_n,
   output logic              load_done,
   output logic              load_err
);

   import cirno9_boot_pkg::*;

   localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_WORD);
   localparam logic [31:0]       MAX_W32   = 32'(MAX_WORDS);

   boot_state_e       state_q, state_d;
   logic [1:0]        hdr_cnt_q, hdr_cnt_d;
   logic [31:0]       nwords_q, nwords_d;
   logic [7:0]        sum_q, sum_d;
   logic [ADDR_W:0]   idx_q, idx_d;
   logic              rdy_q, rdy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              hs;
   logic              push;
   logic              word_last;
   logic [7:0]        sum_add;
   logic [31:0]       n_full;
   logic [ADDR_W-1:0] wr_addr;

   assign hs      = byte_vld && rdy_q;
   assign push    = hs && (state_q == ST_DATA);
   assign sum_add = sum_q + byte_dat;
   assign n_full  = {byte_dat, nwords_q[31:8]};
   // Index carries one extra bit so a full-size image cannot wrap; the address does.
   assign wr_addr = BASE_ADDR + idx_q[ADDR_W-1:0];

   cirno9_byte_packer #(
      .ADDR_W(ADDR_W)
   ) u_packer (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .clr_i      (state_q != ST_DATA),
      .push_i     (push),
      .byte_i     (byte_dat),
      .addr_i     (wr_addr),
      .word_last_o(word_last),
      .we_o       (sram_we),
      .addr_o     (sram_addr),
      .wdata_o    (sram_wdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_SYNC;
         hdr_cnt_q <= '0;
         nwords_q  <= '0;
         sum_q     <= '0;
         idx_q     <= '0;
         rdy_q     <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         hdr_cnt_q <= hdr_cnt_d;
         nwords_q  <= nwords_d;
         sum_q     <= sum_d;
         idx_q     <= idx_d;
         rdy_q     <= rdy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // The sync marker itself is not part of the checksum.
   always_comb begin
      state_d   = state_q;
      hdr_cnt_d = hdr_cnt_q;
      nwords_d  = nwords_q;
      sum_d     = sum_q;
      idx_d     = idx_q;
      if (hs) begin
         case (state_q)
            ST_SYNC, ST_ERR: begin
               if (byte_dat == SYNC_BYTE) begin
                  state_d   = ST_HDR;
                  sum_d     = '0;
                  hdr_cnt_d = '0;
               end
            end
            ST_HDR: begin
               sum_d     = sum_add;
               nwords_d  = n_full;
               hdr_cnt_d = hdr_cnt_q + 2'd1;
               if (hdr_cnt_q == 2'd3) begin
                  idx_d = '0;
                  if (n_full > MAX_W32)       state_d = ST_ERR;
                  else if (n_full == 32'd0)   state_d = ST_CSUM;
                  else                        state_d = ST_DATA;
               end
            end
            ST_DATA: begin
               sum_d = sum_add;
               if (word_last) begin
                  idx_d = idx_q + 1'b1;
                  if (32'(idx_q) + 32'd1 == nwords_q) state_d = ST_CSUM;
               end
            end
            ST_CSUM: begin
               sum_d   = sum_add;
               state_d = (sum_add == 8'd0) ? ST_DONE : ST_ERR;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      rdy_d  = (state_d != ST_DONE);
      done_d = (state_d == ST_DONE);
      err_d  = (state_d == ST_ERR);
   end

   assign byte_rdy   = rdy_q;
   assign core_rst_n = done_q;
   assign load_done  = done_q;
   assign load_err   = err_q;

endmodule

// File: tb/tb_cirno9_boot_loader.sv
// Directed bench for cirno9_boot_loader: framed images, error/retry, boundary
// counts, mid-load reset and stream throughput.
module tb_cirno9_boot_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        byte_vld = 1'b0;
   logic [7:0]  byte_dat = 8'h00;
   logic        byte_rdy;
   logic        sram_we;
   logic [13:0] sram_addr;
   logic [31:0] sram_wdata;
   logic        core_rst_n;
   logic        load_done;
   logic        load_err;

   int checks = 0;
   int failures = 0;
   longint cyc = 0;

   logic [13:0] wa_q[$];
   logic [31:0] wd_q[$];
   logic [7:0]  txq[$];

   logic [31:0] good_w[3] = '{32'h00000013, 32'h00100193, 32'h0000006F};

   cirno9_boot_loader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .byte_vld  (byte_vld),
      .byte_dat  (byte_dat),
      .byte_rdy  (byte_rdy),
      .sram_we   (sram_we),
      .sram_addr (sram_addr),
      .sram_wdata(sram_wdata),
      .core_rst_n(core_rst_n),
      .load_done (load_done),
      .load_err  (load_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (sram_we === 1'b1) begin
         wa_q.push_back(sram_addr);
         wd_q.push_back(sram_wdata);
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Called at posedge+1; returns at posedge+1 right after the handshake edge.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      byte_vld = 1'b1;
      byte_dat = b;
      while (byte_rdy !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (byte_rdy !== 1'b1) begin
         checks++; failures++;
         $display("FAIL send_timeout: byte_rdy=%b required 1 for byte %h", byte_rdy, b);
      end else begin
         @(posedge clk); #1;
      end
      byte_vld = 1'b0;
   endtask

   task automatic send_txq(input int gap_max);
      foreach (txq[i]) begin
         send_byte(txq[i]);
         if (gap_max > 0) begin
            repeat ($urandom_range(gap_max, 0)) begin
               @(posedge clk); #1;
            end
         end
      end
      txq.delete();
   endtask

   // Header and payload of the three-word image, without the checksum byte.
   task automatic push_good_body();
      logic [7:0] body[17] = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h00,
                               8'h13, 8'h00, 8'h00, 8'h00,
                               8'h93, 8'h01, 8'h10, 8'h00,
                               8'h6F, 8'h00, 8'h00, 8'h00};
      foreach (body[i]) txq.push_back(body[i]);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      byte_vld = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      wa_q.delete();
      wd_q.delete();
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({byte_rdy, sram_we, core_rst_n, load_done, load_err} !== 5'b0) begin
         failures++;
         $display("FAIL reset_ctrl: rdy/we/crst/done/err=%b required 00000",
                  {byte_rdy, sram_we, core_rst_n, load_done, load_err});
      end
      checks++;
      if ({sram_addr, sram_wdata} !== 46'd0) begin
         failures++;
         $display("FAIL reset_data: addr=%h wdata=%h required 0/0", sram_addr, sram_wdata);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (byte_rdy !== 1'b0) begin
         failures++;
         $display("FAIL reset_rdy_release: byte_rdy=%b required 0 before first clock", byte_rdy);
      end
      @(posedge clk); #1;
      checks++;
      if (byte_rdy !== 1'b1) begin
         failures++;
         $display("FAIL reset_rdy_after: byte_rdy=%b required 1", byte_rdy);
      end
   endtask

   task automatic test_good_image();
      do_reset();
      push_good_body();
      send_txq(0);
      checks++;
      if ({load_done, core_rst_n} !== 2'b00) begin
         failures++;
         $display("FAIL good_pre_csum: done/crst=%b required 00", {load_done, core_rst_n});
      end
      send_byte(8'hD7);
      checks++;
      if ({load_done, core_rst_n, load_err, byte_rdy} !== 4'b1100) begin
         failures++;
         $display("FAIL good_flags: done/crst/err/rdy=%b required 1100",
                  {load_done, core_rst_n, load_err, byte_rdy});
      end
      checks++;
      if (wa_q.size() != 3) begin
         failures++;
         $display("FAIL good_wcount: writes=%0d required 3", wa_q.size());
      end
      for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
         checks++;
         if (wa_q[i] !== 14'(i) || wd_q[i] !== good_w[i]) begin
            failures++;
            $display("FAIL good_word%0d: addr=%0d data=%h required addr=%0d data=%h",
                     i, wa_q[i], wd_q[i], i, good_w[i]);
         end
      end
   endtask

   task automatic test_bad_checksum();
      do_reset();
      push_good_body();
      txq.push_back(8'hD8);
      send_txq(0);
      checks++;
      if ({load_err, core_rst_n, load_done, byte_rdy} !== 4'b1001) begin
         failures++;
         $display("FAIL bad_flags: err/crst/done/rdy=%b required 1001",
                  {load_err, core_rst_n, load_done, byte_rdy});
      end
      checks++;
      if (wa_q.size() != 3) begin
         failures++;
         $display("FAIL bad_wcount: writes=%0d required 3", wa_q.size());
      end
      send_byte(8'hA5);
      checks++;
      if (load_err !== 1'b0) begin
         failures++;
         $display("FAIL retry_err_clear: load_err=%b required 0", load_err);
      end
      push_good_body();
      void'(txq.pop_front());
      txq.push_back(8'hD7);
      send_txq(0);
      checks++;
      if ({load_err, load_done, core_rst_n} !== 3'b011) begin
         failures++;
         $display("FAIL retry_flags: err/done/crst=%b required 011",
                  {load_err, load_done, core_rst_n});
      end
      checks++;
      if (wa_q.size() != 6 || wa_q[5] !== 14'd2 || wd_q[5] !== 32'h0000006F) begin
         failures++;
         $display("FAIL retry_writes: count=%0d last=%h required 6 writes ending 0000006F",
                  wa_q.size(), (wd_q.size() > 0) ? wd_q[wd_q.size()-1] : 32'h0);
      end
   endtask

   // The checksum covers the count, payload and C, so an empty image needs C=00.
   task automatic test_empty_image();
      logic [7:0] f[9] = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      do_reset();
      foreach (f[i]) txq.push_back(f[i]);
      send_txq(0);
      checks++;
      if ({load_done, core_rst_n, load_err} !== 3'b110) begin
         failures++;
         $display("FAIL empty_flags: done/crst/err=%b required 110",
                  {load_done, core_rst_n, load_err});
      end
      checks++;
      if (wa_q.size() != 0) begin
         failures++;
         $display("FAIL empty_wcount: writes=%0d required 0", wa_q.size());
      end
   endtask

   task automatic test_oversize();
      logic [7:0] f[5] = '{8'hA5, 8'h01, 8'h40, 8'h00, 8'h00};
      do_reset();
      foreach (f[i]) txq.push_back(f[i]);
      send_txq(0);
      checks++;
      if ({load_err, core_rst_n, load_done} !== 3'b100) begin
         failures++;
         $display("FAIL oversize_flags: err/crst/done=%b required 100",
                  {load_err, core_rst_n, load_done});
      end
      txq.push_back(8'h13); txq.push_back(8'h00); txq.push_back(8'h00); txq.push_back(8'h00);
      send_txq(0);
      checks++;
      if (wa_q.size() != 0 || load_err !== 1'b1) begin
         failures++;
         $display("FAIL oversize_nowrite: writes=%0d err=%b required 0 writes err=1",
                  wa_q.size(), load_err);
      end
   endtask

   task automatic test_reset_midload();
      do_reset();
      push_good_body();
      repeat (7) void'(txq.pop_back());
      send_txq(0);
      checks++;
      if (wa_q.size() != 1 || sram_wdata !== 32'h00000013) begin
         failures++;
         $display("FAIL midload_pre: writes=%0d wdata=%h required 1 write 00000013",
                  wa_q.size(), sram_wdata);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({byte_rdy, sram_we, core_rst_n, load_done, load_err} !== 5'b0 ||
          sram_addr !== 14'd0 || sram_wdata !== 32'd0) begin
         failures++;
         $display("FAIL midload_reset: ctrl=%b addr=%h wdata=%h required all zero",
                  {byte_rdy, sram_we, core_rst_n, load_done, load_err}, sram_addr, sram_wdata);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      wa_q.delete();
      wd_q.delete();
      push_good_body();
      txq.push_back(8'hD7);
      send_txq(0);
      checks++;
      if (wa_q.size() != 3 || load_done !== 1'b1) begin
         failures++;
         $display("FAIL midload_reload: writes=%0d done=%b required 3 writes done=1",
                  wa_q.size(), load_done);
      end
      for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
         checks++;
         if (wa_q[i] !== 14'(i) || wd_q[i] !== good_w[i]) begin
            failures++;
            $display("FAIL midload_word%0d: addr=%0d data=%h required addr=%0d data=%h",
                     i, wa_q[i], wd_q[i], i, good_w[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] f[10] = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00,
                            8'hA5, 8'h00, 8'h00, 8'hA5, 8'hB5};
      do_reset();
      push_good_body();
      txq.push_back(8'hD7);
      send_txq(3);
      checks++;
      if (wa_q.size() != 3 || load_done !== 1'b1) begin
         failures++;
         $display("FAIL gaps_status: writes=%0d done=%b required 3 writes done=1",
                  wa_q.size(), load_done);
      end
      for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
         checks++;
         if (wa_q[i] !== 14'(i) || wd_q[i] !== good_w[i]) begin
            failures++;
            $display("FAIL gaps_word%0d: addr=%0d data=%h required addr=%0d data=%h",
                     i, wa_q[i], wd_q[i], i, good_w[i]);
         end
      end
      // Sync marker values inside the count and payload are plain data.
      do_reset();
      foreach (f[i]) txq.push_back(f[i]);
      send_txq(2);
      checks++;
      if (wa_q.size() != 1 || wd_q[0] !== 32'hA50000A5 || load_done !== 1'b1) begin
         failures++;
         $display("FAIL sync_as_data: writes=%0d data=%h done=%b required 1 write A50000A5 done=1",
                  wa_q.size(), (wd_q.size() > 0) ? wd_q[0] : 32'h0, load_done);
      end
   endtask

   // Full-size image streamed with byte_vld held high; payload byte k is k[7:0].
   task automatic test_back_to_back();
      longint t0;
      int     bad;
      logic [7:0] b;
      do_reset();
      txq.push_back(8'hA5);
      txq.push_back(8'h00); txq.push_back(8'h40); txq.push_back(8'h00); txq.push_back(8'h00);
      for (int k = 0; k < 65536; k++) txq.push_back(8'(k));
      txq.push_back(8'hC0);
      t0 = cyc;
      send_txq(0);
      checks++;
      if (cyc - t0 != 65542) begin
         failures++;
         $display("FAIL b2b_cycles: cycles=%0d required 65542", cyc - t0);
      end
      checks++;
      if ({load_done, load_err} !== 2'b10) begin
         failures++;
         $display("FAIL max_flags: done/err=%b required 10", {load_done, load_err});
      end
      checks++;
      if (wa_q.size() != 16384 || wa_q[wa_q.size()-1] !== 14'd16383) begin
         failures++;
         $display("FAIL max_last: writes=%0d last_addr=%0d required 16384 writes last 16383",
                  wa_q.size(), (wa_q.size() > 0) ? wa_q[wa_q.size()-1] : 14'd0);
      end
      bad = 0;
      for (int i = 0; i < wa_q.size(); i++) begin
         b = 8'(4 * i);
         if (wa_q[i] !== 14'(i) ||
             wd_q[i] !== {b + 8'd3, b + 8'd2, b + 8'd1, b}) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL max_contents: bad_words=%0d required 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_good_image();
      test_bad_checksum();
      test_empty_image();
      test_oversize();
      test_reset_midload();
      test_backpressure();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
